// File: rtl/cv32e40p_mem_arbiter.sv
// cv32e40p_mem_arbiter
// Shares one single-port, 1-cycle-latency BRAM between the cv32e40p
// instruction and data OBI ports. Grants are combinational in the request
// cycle and each response returns to its requester one cycle later.
//
// Build option: define CV32E40P_MEM_ARB_RR_EN for round-robin arbitration
// between the two ports. Without it, the data port has fixed priority.
module cv32e40p_mem_arbiter #(
  parameter int unsigned MEM_WORDS = 16384,
  localparam int unsigned IDX_W = $clog2(MEM_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,

  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,

  output logic             mem_en_o,
  output logic [3:0]       mem_we_o,
  output logic [IDX_W-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  // Port that owns the BRAM response arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e           owner_q;
  owner_e           owner_next;

  logic             grant_instr;
  logic             grant_data;
  logic             any_grant;

  // Address and write data are held when idle so the BRAM pins stay quiet.
  logic [IDX_W-1:0] mem_addr_reg;
  logic [IDX_W-1:0] mem_addr_next;
  logic [31:0]      mem_wdata_reg;
  logic [31:0]      mem_wdata_next;

  // Byte bits and bits above the BRAM size are ignored: addresses wrap.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i[31:IDX_W+2], instr_addr_i[1:0],
                              data_addr_i[31:IDX_W+2],  data_addr_i[1:0]};

`ifdef CV32E40P_MEM_ARB_RR_EN
  // Winner of the most recent contended cycle.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  port_e last_q;

  // Round-robin grant: on contention the port that lost last time wins.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (last_q == PORT_DATA) begin
          grant_instr = 1'b1;
        end else begin
          grant_data  = 1'b1;
        end
      end else begin
        grant_instr = instr_req_i;
        grant_data  = data_req_i;
      end
    end
  end

  // Remember the contention winner; uncontended cycles leave it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PORT_DATA;
    end else if (instr_req_i && data_req_i) begin
      last_q <= grant_instr ? PORT_INSTR : PORT_DATA;
    end
  end
`else
  // Fixed priority: the data port always wins contention.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (!rst_i) begin
      grant_data  = data_req_i;
      grant_instr = instr_req_i && !data_req_i;
    end
  end
`endif

  assign any_grant   = grant_instr || grant_data;
  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;
  assign mem_en_o    = any_grant;

  // Only a granted data store may write; the fetch port is read-only.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
      assign mem_we_o[gi] = grant_data && data_we_i && data_be_i[gi];
    end
  endgenerate

  // Steer the granted port onto the BRAM address/data, else hold.
  always_comb begin
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    owner_next     = OWN_NONE;
    if (grant_instr) begin
      mem_addr_next  = instr_addr_i[IDX_W+1:2];
      mem_wdata_next = data_wdata_i;
      owner_next     = OWN_INSTR;
    end else if (grant_data) begin
      mem_addr_next  = data_addr_i[IDX_W+1:2];
      mem_wdata_next = data_wdata_i;
      owner_next     = OWN_DATA;
    end
  end

  assign mem_addr_o  = mem_addr_next;
  assign mem_wdata_o = mem_wdata_next;

  // Track the response owner and the held BRAM address/data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q       <= OWN_NONE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      owner_q       <= owner_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Route the BRAM read data to the owner only; reset suppresses responses.
  assign instr_rvalid_o = !rst_i && (owner_q == OWN_INSTR);
  assign data_rvalid_o  = !rst_i && (owner_q == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_cv32e40p_mem_arbiter.sv
// Directed bench for cv32e40p_mem_arbiter with a behavioural 1-cycle BRAM.
module tb_cv32e40p_mem_arbiter;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
`ifdef CV32E40P_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_req;
  logic [31:0]      instr_addr;
  logic             instr_gnt;
  logic             instr_rvalid;
  logic [31:0]      instr_rdata;
  logic             data_req;
  logic             data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_addr;
  logic [31:0]      data_wdata;
  logic             data_gnt;
  logic             data_rvalid;
  logic [31:0]      data_rdata;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = 32'h0;

  logic [31:0]      bram [MEM_WORDS];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cv32e40p_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  // Read-first single-port BRAM with byte writes and 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= bram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) bram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_i;
    logic prev_i;

    bram[2]  = 32'h2222_2222;
    bram[4]  = 32'hDEAD_BEEF;
    bram[8]  = 32'hAAAA_AAAA;
    bram[16] = 32'h0BAD_F00D;

    // Reset with both requests and a store pending: everything forced off.
    rst = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h10;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
    data_addr = 32'h40; data_wdata = 32'h5555_5555;
    next_cycle();
    #1;
    chk("rst_igrant", {31'b0, instr_gnt}, 32'd0);
    chk("rst_dgrant", {31'b0, data_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst_irvalid", {31'b0, instr_rvalid}, 32'd0);
    chk("rst_drvalid", {31'b0, data_rvalid}, 32'd0);
    $display("reset: grants/enables held low");

    // Continuous contention starting in the first cycle after reset.
    next_cycle();
    rst = 1'b0; data_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      #1;
      exp_i = RR && (k % 2 == 0);
      chk($sformatf("cont%0d_igrant", k), {31'b0, instr_gnt}, {31'b0, exp_i});
      chk($sformatf("cont%0d_dgrant", k), {31'b0, data_gnt}, {31'b0, !exp_i});
      chk($sformatf("cont%0d_addr", k), 32'(mem_addr), exp_i ? 32'd4 : 32'd16);
      if (k > 0) begin
        prev_i = RR && ((k - 1) % 2 == 0);
        chk($sformatf("cont%0d_irvalid", k), {31'b0, instr_rvalid}, {31'b0, prev_i});
        chk($sformatf("cont%0d_drvalid", k), {31'b0, data_rvalid}, {31'b0, !prev_i});
        chk($sformatf("cont%0d_irdata", k), instr_rdata, prev_i ? 32'hDEAD_BEEF : 32'h0);
        chk($sformatf("cont%0d_drdata", k), data_rdata, prev_i ? 32'h0 : 32'h0BAD_F00D);
      end
      $display("contention cycle %0d: igrant=%0b dgrant=%0b", k, instr_gnt, data_gnt);
    end

    // Idle cycle: last data response arrives, address holds.
    next_cycle();
    instr_req = 1'b0; data_req = 1'b0;
    #1;
    chk("idle_grants", {30'b0, instr_gnt, data_gnt}, 32'd0);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    chk("idle_addr_hold", 32'(mem_addr), 32'd16);
    chk("idle_drvalid", {31'b0, data_rvalid}, 32'd1);
    chk("idle_drdata", data_rdata, 32'h0BAD_F00D);
    chk("idle_irvalid", {31'b0, instr_rvalid}, 32'd0);
    $display("idle: last data response 0x%08h", data_rdata);

    // Single fetch from word 4.
    next_cycle();
    instr_req = 1'b1; instr_addr = 32'h0000_0010;
    #1;
    chk("fetch_igrant", {31'b0, instr_gnt}, 32'd1);
    chk("fetch_dgrant", {31'b0, data_gnt}, 32'd0);
    chk("fetch_addr", 32'(mem_addr), 32'd4);
    chk("fetch_we", {28'b0, mem_we}, 32'd0);
    next_cycle();
    instr_req = 1'b0;
    #1;
    chk("fetch_irvalid", {31'b0, instr_rvalid}, 32'd1);
    chk("fetch_irdata", instr_rdata, 32'hDEAD_BEEF);
    chk("fetch_drvalid", {31'b0, data_rvalid}, 32'd0);
    chk("fetch_drdata", data_rdata, 32'h0);
    $display("fetch 0x10: rdata 0x%08h", instr_rdata);

    // Half-word store to word 8 followed by a load of the same word.
    next_cycle();
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h20; data_wdata = 32'h1234_5678;
    #1;
    chk("store_dgrant", {31'b0, data_gnt}, 32'd1);
    chk("store_we", {28'b0, mem_we}, 32'h3);
    chk("store_addr", 32'(mem_addr), 32'd8);
    chk("store_wdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    data_we = 1'b0;
    #1;
    chk("load_dgrant", {31'b0, data_gnt}, 32'd1);
    chk("load_we", {28'b0, mem_we}, 32'd0);
    chk("store_drvalid", {31'b0, data_rvalid}, 32'd1);
    next_cycle();
    data_req = 1'b0;
    #1;
    chk("load_drvalid", {31'b0, data_rvalid}, 32'd1);
    chk("load_drdata", data_rdata, 32'hAAAA_5678);
    next_cycle();
    #1;
    chk("load_single_rvalid", {31'b0, data_rvalid}, 32'd0);
    $display("store/load 0x20: rdata 0xAAAA5678 expected");

    // Wrapped fetch; a stray data_we must not make the fetch write.
    next_cycle();
    instr_req = 1'b1; instr_addr = MEM_WORDS * 4 + 8;
    data_we = 1'b1; data_be = 4'hF;
    #1;
    chk("wrap_igrant", {31'b0, instr_gnt}, 32'd1);
    chk("wrap_addr", 32'(mem_addr), 32'd2);
    chk("wrap_we", {28'b0, mem_we}, 32'd0);
    next_cycle();
    instr_req = 1'b0; data_we = 1'b0;
    #1;
    chk("wrap_irdata", instr_rdata, 32'h2222_2222);
    $display("wrap fetch: word index 2");

    // Reset mid-operation drops the pending load response.
    next_cycle();
    data_req = 1'b1; data_addr = 32'h40;
    #1;
    chk("mid_dgrant", {31'b0, data_gnt}, 32'd1);
    next_cycle();
    rst = 1'b1; data_req = 1'b0;
    #1;
    chk("mid_rst_drvalid", {31'b0, data_rvalid}, 32'd0);
    chk("mid_rst_irvalid", {31'b0, instr_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h10;
    data_req = 1'b1; data_addr = 32'h40;
    #1;
    chk("post_rst_drvalid", {31'b0, data_rvalid}, 32'd0);
    chk("post_rst_irvalid", {31'b0, instr_rvalid}, 32'd0);
    chk("post_rst_igrant", {31'b0, instr_gnt}, {31'b0, RR});
    chk("post_rst_dgrant", {31'b0, data_gnt}, {31'b0, !RR});
    next_cycle();
    instr_req = 1'b0; data_req = 1'b0;
    #1;
    chk("post_rst_irdata", instr_rdata, RR ? 32'hDEAD_BEEF : 32'h0);
    chk("post_rst_drdata", data_rdata, RR ? 32'h0 : 32'h0BAD_F00D);
    $display("reset mid-operation: pending response dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
